// File: rtl/halfword_splitter_if.sv
// Valid/ready word-in / halfword-out bus of the halfword splitter.
// The splitter uses the slave modport; the upstream/downstream side uses master.
interface halfword_splitter_if #(
  parameter int HALF_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*HALF_W-1:0]   in_word;
  logic                  out_valid;
  logic                  out_ready;
  logic [HALF_W-1:0]     out_half;
  logic                  out_upper;
  logic                  out_last;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_half, out_upper, out_last
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_half, out_upper, out_last
  );
endinterface

// File: rtl/halfword_splitter.sv
// Splits each 32-bit word into an upper then a lower halfword beat.
// Optional macro HALFWORD_SPLITTER_SKIP_ZERO_EN drops the lower beat when it is zero.
module halfword_splitter #(
  parameter int HALF_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  halfword_splitter_if.slave   bus,
  output logic [CNT_W-1:0]     word_count
);

  typedef enum logic [1:0] {IDLE, UPPER, LOWER} state_t;

  state_t            state;
  logic [HALF_W-1:0] lower;
  logic              accept;
  logic              done;
  logic              upper_is_last;
  logic              new_skip;

`ifdef HALFWORD_SPLITTER_SKIP_ZERO_EN
  logic skip;

  assign new_skip      = (bus.in_word[HALF_W-1:0] == '0);
  assign upper_is_last = skip;

  always_ff @(posedge clk) begin
    if (rst)
      skip <= 1'b0;
    else if (accept)
      skip <= new_skip;
  end
`else
  assign new_skip      = 1'b0;
  assign upper_is_last = 1'b0;
`endif

  // The next word may enter on the cycle the current word's final beat is taken.
  always_comb begin
    bus.in_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    bus.in_ready = 1'b1;
        UPPER:   bus.in_ready = upper_is_last & bus.out_ready;
        LOWER:   bus.in_ready = bus.out_ready;
        default: bus.in_ready = 1'b0;
      endcase
    end
  end

  assign accept = bus.in_valid & bus.in_ready;
  assign done   = bus.out_valid & bus.out_ready &
                  ((state == LOWER) | ((state == UPPER) & upper_is_last));

  // Only the lower half needs holding; the upper half goes straight to out_half.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lower         <= '0;
      word_count    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_half  <= '0;
      bus.out_upper <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      if (done)
        word_count <= word_count + CNT_W'(1);

      if (accept) begin
        state         <= UPPER;
        lower         <= bus.in_word[HALF_W-1:0];
        bus.out_valid <= 1'b1;
        bus.out_half  <= bus.in_word[2*HALF_W-1:HALF_W];
        bus.out_upper <= 1'b1;
        bus.out_last  <= new_skip;
      end else if (done) begin
        state         <= IDLE;
        bus.out_valid <= 1'b0;
        bus.out_half  <= '0;
        bus.out_upper <= 1'b0;
        bus.out_last  <= 1'b0;
      end else if (state == UPPER && bus.out_ready) begin
        state         <= LOWER;
        bus.out_half  <= lower;
        bus.out_upper <= 1'b0;
        bus.out_last  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_halfword_splitter.sv
// Directed-vector bench for halfword_splitter; expectations are hand-computed.
// Honours HALFWORD_SPLITTER_SKIP_ZERO_EN for the zero-lower-half word.
module tb_halfword_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] word_count;
  int          vectors = 0;
  int          miscompares = 0;
  int          beats = 0;

  halfword_splitter_if #(.HALF_W(16)) bus ();

  halfword_splitter #(.HALF_W(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && bus.out_valid && bus.out_ready)
      beats++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic checkBeat(input string tag, input logic v, input logic u,
                           input logic l, input logic [15:0] h);
    checkOutput(tag, {13'b0, bus.out_valid, bus.out_upper, bus.out_last, bus.out_half},
                {13'b0, v, u, l, h});
  endtask

  task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] w,
                               input logic ordy);
    rst          = r;
    bus.in_valid = iv;
    bus.in_word  = w;
    bus.out_ready = ordy;
    #1;
  endtask

  logic [31:0] stream [3] = '{32'hAAAA5555, 32'h0F0FF0F0, 32'hDEADBEEF};
  int          beatsBefore;

  initial begin
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkBeat("reset_beat", 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    checkOutput("reset_count", {16'b0, word_count}, 32'd0);

    // Reset during the lower beat: word dropped, counter stays at its reset value.
    applyStimulus(1'b0, 1'b1, 32'h11112222, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h11112222, 1'b1);
    checkBeat("rstmid_upper", 1'b1, 1'b1, 1'b0, 16'h1111);
    @(negedge clk);
    checkBeat("rstmid_lower", 1'b1, 1'b0, 1'b1, 16'h2222);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkBeat("rstmid_after", 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("rstmid_in_ready", {31'b0, bus.in_ready}, 32'd0);
    checkOutput("rstmid_count", {16'b0, word_count}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkBeat("rstmid_idle", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Single word, consumer always ready.
    applyStimulus(1'b0, 1'b1, 32'h1234ABCD, 1'b1);
    checkOutput("single_accept", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkBeat("single_upper", 1'b1, 1'b1, 1'b0, 16'h1234);
    @(negedge clk);
    checkBeat("single_lower", 1'b1, 1'b0, 1'b1, 16'hABCD);
    @(negedge clk);
    checkBeat("single_idle", 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("single_count", {16'b0, word_count}, 32'd1);

    // Back-to-back stream: next word taken on the previous word's lower beat.
    applyStimulus(1'b0, 1'b1, stream[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkBeat($sformatf("b2b_upper%0d", i), 1'b1, 1'b1, 1'b0, stream[i][31:16]);
      checkOutput($sformatf("b2b_upper_rdy%0d", i), {31'b0, bus.in_ready}, 32'd0);
      if (i < 2) applyStimulus(1'b0, 1'b1, stream[i+1], 1'b1);
      else       applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkBeat($sformatf("b2b_lower%0d", i), 1'b1, 1'b0, 1'b1, stream[i][15:0]);
      checkOutput($sformatf("b2b_lower_rdy%0d", i), {31'b0, bus.in_ready}, 32'd1);
    end
    @(negedge clk);
    checkBeat("b2b_idle", 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("b2b_count", {16'b0, word_count}, 32'd4);

    // Backpressure: 3 stall cycles on upper, 2 on lower.
    beatsBefore = beats;
    applyStimulus(1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkBeat($sformatf("bp_upper%0d", i), 1'b1, 1'b1, 1'b0, 16'hCAFE);
      checkOutput($sformatf("bp_upper_rdy%0d", i), {31'b0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkBeat($sformatf("bp_lower%0d", i), 1'b1, 1'b0, 1'b1, 16'hF00D);
      if (i < 2)
        checkOutput($sformatf("bp_lower_rdy%0d", i), {31'b0, bus.in_ready}, 32'd0);
      @(negedge clk);
    end
    checkBeat("bp_idle", 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("bp_beats", beats - beatsBefore, 32'd2);
    checkOutput("bp_count", {16'b0, word_count}, 32'd5);

    // Word with a zero lower half.
    applyStimulus(1'b0, 1'b1, 32'h56780000, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef HALFWORD_SPLITTER_SKIP_ZERO_EN
    checkBeat("skip_upper", 1'b1, 1'b1, 1'b1, 16'h5678);
    checkOutput("skip_upper_rdy", {31'b0, bus.in_ready}, 32'd1);
`else
    checkBeat("skip_upper", 1'b1, 1'b1, 1'b0, 16'h5678);
    checkOutput("skip_upper_rdy", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk);
    checkBeat("skip_lower", 1'b1, 1'b0, 1'b1, 16'h0000);
`endif
    @(negedge clk);
    checkBeat("skip_idle", 1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("skip_count", {16'b0, word_count}, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
